// File: rtl/lfsr_bank_if.sv
// rtl/lfsr_bank_if.sv - request/response and configuration bundle for lfsr_bank
interface lfsr_bank_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
);
  logic                      load;
  logic [CHANNELS*WIDTH-1:0] seed_in;
  logic [CHANNELS*WIDTH-1:0] poly_in;
  logic                      start;
  logic [CNT_W-1:0]          steps;
  logic                      busy;
  logic                      ready;
  logic [CHANNELS*WIDTH-1:0] data_out;
  logic [CHANNELS-1:0]       lockup;

  modport master (
    output load, seed_in, poly_in, start, steps,
    input  busy, ready, data_out, lockup
  );

  modport slave (
    input  load, seed_in, poly_in, start, steps,
    output busy, ready, data_out, lockup
  );
endinterface

// File: rtl/lfsr_bank.sv
// rtl/lfsr_bank.sv - N lock-step LFSRs with start/ready handshake and per-request step count
// Define LFSR_LOCKUP_RECOVER_EN to enable all-zero state recovery and the sticky lockup flags.
module lfsr_bank #(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 2,
  parameter int               CNT_W     = 8,
  parameter int               GALOIS    = 0,
  parameter logic [WIDTH-1:0] INIT_SEED = 1,
  parameter logic [WIDTH-1:0] INIT_POLY = 8'hB8
) (
  input  logic       clk,
  input  logic       rst_n,
  lfsr_bank_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]                remaining;
  logic [CHANNELS-1:0][WIDTH-1:0]  poly_q;
  logic [CHANNELS-1:0][WIDTH-1:0]  lfsr_q;
  logic [CHANNELS-1:0][WIDTH-1:0]  lfsr_nxt;
  logic [CHANNELS-1:0][WIDTH-1:0]  dout_q;
  logic                            ready_q;

  logic accept_load;
  logic accept_start;
  logic advance;
  logic publish;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] p);
    if (GALOIS != 0)
      return {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & p);
    else
      return {s[WIDTH-2:0], ^(s & p)};
  endfunction

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic [CHANNELS-1:0] zero_state;
  logic [CHANNELS-1:0] lockup_q;

  // An all-zero channel is reseeded with 1 instead of stepping; it still costs one step.
  always_comb begin
    zero_state = '0;
    lfsr_nxt   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      zero_state[c] = (lfsr_q[c] == '0);
      if (zero_state[c])
        lfsr_nxt[c] = {{(WIDTH-1){1'b0}}, 1'b1};
      else
        lfsr_nxt[c] = lfsr_step(lfsr_q[c], poly_q[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lockup_q <= '0;
    else if (accept_load)
      lockup_q <= '0;
    else if (advance)
      lockup_q <= lockup_q | zero_state;
  end

  assign bus.lockup = lockup_q;
`else
  always_comb begin
    lfsr_nxt = '0;
    for (int c = 0; c < CHANNELS; c++)
      lfsr_nxt[c] = lfsr_step(lfsr_q[c], poly_q[c]);
  end

  assign bus.lockup = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Load has priority over start; both are only honoured in IDLE.
  always_comb begin
    state_nxt    = state;
    accept_load  = 1'b0;
    accept_start = 1'b0;
    advance      = 1'b0;
    publish      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          accept_load = 1'b1;
        end else if (bus.start) begin
          accept_start = 1'b1;
          state_nxt    = (bus.steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        advance = 1'b1;
        if (remaining == CNT_W'(1))
          state_nxt = DONE;
      end
      DONE: begin
        publish   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      poly_q    <= {CHANNELS{INIT_POLY}};
      lfsr_q    <= {CHANNELS{INIT_SEED}};
      dout_q    <= {CHANNELS{INIT_SEED}};
      ready_q   <= 1'b0;
    end else begin
      ready_q <= publish;
      if (accept_load) begin
        poly_q <= bus.poly_in;
        lfsr_q <= bus.seed_in;
      end
      if (accept_start)
        remaining <= bus.steps;
      if (advance) begin
        lfsr_q    <= lfsr_nxt;
        remaining <= remaining - CNT_W'(1);
      end
      if (publish)
        dout_q <= lfsr_q;
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.ready    = ready_q;
  assign bus.data_out = dout_q;

endmodule

// File: tb/tb_lfsr_bank.sv
// tb/tb_lfsr_bank.sv - directed self-checking bench for lfsr_bank in Fibonacci and Galois builds
module tb_lfsr_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc;
  int   bcnt;
  int   pulses;

  always #5 clk = ~clk;

  lfsr_bank_if #(.WIDTH(8), .CHANNELS(2), .CNT_W(8)) fb ();
  lfsr_bank_if #(.WIDTH(8), .CHANNELS(2), .CNT_W(8)) gb ();

  lfsr_bank #(.WIDTH(8), .CHANNELS(2), .CNT_W(8), .GALOIS(0),
              .INIT_SEED(8'h01), .INIT_POLY(8'hB8)) u_fib (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fb)
  );

  lfsr_bank #(.WIDTH(8), .CHANNELS(2), .CNT_W(8), .GALOIS(1),
              .INIT_SEED(8'h01), .INIT_POLY(8'hB8)) u_gal (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (gb)
  );

  function automatic logic [7:0] fib_model(input logic [7:0] s, input logic [7:0] p, input int n);
    logic [7:0] v;
    v = s;
    for (int i = 0; i < n; i++)
      v = {v[6:0], ^(v & p)};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fib_load(input logic [15:0] seed, input logic [15:0] poly);
    fb.seed_in = seed;
    fb.poly_in = poly;
    fb.load    = 1'b1;
    tick();
    fb.load    = 1'b0;
  endtask

  // cyc = edges after the accepting edge until ready is seen (0 on timeout).
  task automatic fib_request(input int n, input int disturb, output int cyc_o, output int bcnt_o);
    fb.steps = 8'(n);
    fb.start = 1'b1;
    tick();
    fb.start = 1'b0;
    fb.steps = '0;
    cyc_o  = 0;
    bcnt_o = fb.busy ? 1 : 0;
    for (int k = 1; k <= n + 20 && cyc_o == 0; k++) begin
      if (k == disturb) begin
        fb.load    = 1'b1;
        fb.start   = 1'b1;
        fb.seed_in = 16'hFFFF;
        fb.poly_in = 16'h0000;
        fb.steps   = 8'd3;
      end
      tick();
      fb.load  = 1'b0;
      fb.start = 1'b0;
      if (fb.ready) cyc_o = k;
      else if (fb.busy) bcnt_o++;
    end
  endtask

  initial begin
    fb.load = 1'b0; fb.start = 1'b0; fb.steps = '0; fb.seed_in = '0; fb.poly_in = '0;
    gb.load = 1'b0; gb.start = 1'b0; gb.steps = '0; gb.seed_in = '0; gb.poly_in = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_busy",   32'(fb.busy),     32'h0);
    chk("rst_ready",  32'(fb.ready),    32'h0);
    chk("rst_dout",   32'(fb.data_out), 32'h0101);
    chk("rst_lockup", 32'(fb.lockup),   32'h0);
    chk("rst_gdout",  32'(gb.data_out), 32'h0101);

    // Fibonacci, reset seed 01 / poly B8: 02,04,08,11
    fib_request(4, 0, cyc, bcnt);
    chk("fib4_cycles", 32'(cyc),         32'd5);
    chk("fib4_busy",   32'(bcnt),        32'd5);
    chk("fib4_dout",   32'(fb.data_out), 32'h1111);
    chk("fib4_busyoff",32'(fb.busy),     32'h0);
    tick();
    chk("fib4_pulse",  32'(fb.ready),    32'h0);

    // Galois: ch0 80 -> 1D, ch1 01 -> 02
    gb.seed_in = 16'h0180;
    gb.poly_in = 16'h1D1D;
    gb.load    = 1'b1;
    tick();
    gb.load  = 1'b0;
    gb.steps = 8'd1;
    gb.start = 1'b1;
    tick();
    gb.start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (gb.ready) pulses++;
    end
    chk("gal_dout",   32'(gb.data_out), 32'h021D);
    chk("gal_pulses", 32'(pulses),      32'd1);

    // All-zero channel 0
    fib_load(16'h0100, 16'hB8B8);
    chk("load_keeps_dout", 32'(fb.data_out), 32'h1111);
    fib_request(2, 0, cyc, bcnt);
    chk("zero_cycles", 32'(cyc), 32'd3);
`ifdef LFSR_LOCKUP_RECOVER_EN
    chk("zero_dout",   32'(fb.data_out), 32'h0402);
    chk("zero_lockup", 32'(fb.lockup),   32'h1);
`else
    chk("zero_dout",   32'(fb.data_out), 32'h0400);
    chk("zero_lockup", 32'(fb.lockup),   32'h0);
`endif
    tick();
    fib_load(16'h0101, 16'hB8B8);
    chk("load_clr_lockup", 32'(fb.lockup), 32'h0);

    // steps=0: states unchanged, one busy cycle
    fib_load(16'h5AC3, 16'hB8B8);
    fib_request(0, 0, cyc, bcnt);
    chk("zero_steps_cycles", 32'(cyc),         32'd1);
    chk("zero_steps_busy",   32'(bcnt),        32'd1);
    chk("zero_steps_dout",   32'(fb.data_out), 32'h5AC3);

    // Back-to-back: start accepted in the ready cycle
    fib_request(1, 0, cyc, bcnt);
    chk("b2b_cycles", 32'(cyc),         32'd2);
    chk("b2b_dout",   32'(fb.data_out), {16'h0, fib_model(8'h5A, 8'hB8, 1), fib_model(8'hC3, 8'hB8, 1)});
    tick();

    // load/start during RUN are ignored
    fib_load(16'h0301, 16'hB8B8);
    fib_request(100, 10, cyc, bcnt);
    chk("run100_cycles", 32'(cyc), 32'd101);
    chk("run100_dout",   32'(fb.data_out),
        {16'h0, fib_model(8'h03, 8'hB8, 100), fib_model(8'h01, 8'hB8, 100)});
    tick();
    chk("run100_idle", 32'(fb.busy), 32'h0);

    // Max step count completes without wrap
    fib_load(16'h0101, 16'hB8B8);
    fib_request(255, 0, cyc, bcnt);
    chk("max_cycles", 32'(cyc), 32'd256);
    chk("max_dout",   32'(fb.data_out),
        {16'h0, fib_model(8'h01, 8'hB8, 255), fib_model(8'h01, 8'hB8, 255)});
    tick();

    // Reset mid-request
    fib_load(16'h3344, 16'hB8B8);
    fb.steps = 8'd100;
    fb.start = 1'b1;
    tick();
    fb.start = 1'b0;
    repeat (10) tick();
    chk("mid_busy_pre", 32'(fb.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy",  32'(fb.busy),     32'h0);
    chk("mid_ready", 32'(fb.ready),    32'h0);
    chk("mid_dout",  32'(fb.data_out), 32'h0101);
    repeat (2) tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (fb.ready || fb.busy) pulses++;
    end
    chk("mid_no_ready", 32'(pulses), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
